// File: rtl/rr_mux_sched_pkg.sv
// ============================================================================
// Module : rr_mux_sched_pkg
// Brief  : Shared constants, FSM state type and one-hot helper for the
//          round-robin mux scheduler.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rr_mux_sched_pkg;

    localparam int N_REQ = 16;
    localparam int SEL_W = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] onehot4to16(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mux16to1.sv
// ============================================================================
// Module : mux16to1
// Brief  : Single-bit 16:1 selection lane of the shared datapath.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux16to1 (
    input  logic [15:0] d,
    input  logic [3:0]  s,
    output logic        y
);

    assign y = d[s];

endmodule

`default_nettype wire

// File: rtl/rr_mux_scheduler_rr_pick.sv
// ============================================================================
// Module : rr_pick
// Brief  : Combinational round-robin winner: rotate by ptr, pick the lowest
//          set bit, then rotate the index back.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
    import rr_mux_sched_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] winner
);

    logic [N_REQ-1:0] w_rot;
    logic [SEL_W-1:0] w_idx;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            w_rot[i] = req[SEL_W'(i) + ptr];
        end
    end

    // Descending scan so the lowest rotated position (closest to ptr) wins.
    always_comb begin
        w_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_idx = SEL_W'(i);
            end
        end
    end

    assign any    = |req;
    assign winner = w_idx + ptr;

endmodule

`default_nettype wire

// File: rtl/rr_mux_scheduler.sv
// ============================================================================
// Module : rr_mux_scheduler
// Brief  : 16-requester round-robin scheduler driving a shared 16:1 mux onto
//          a registered valid/ready channel with one-hot ack.
//          Optional bubble-free bursts: define RR_MUX_SCHEDULER_BURST_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_mux_scheduler
    import rr_mux_sched_pkg::*;
#(
    parameter int unsigned W         = 1,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] in_data,
    output logic [SEL_W-1:0]   sel,
    output logic [N_REQ-1:0]   gnt,
    output logic [W-1:0]       out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N_REQ-1:0]   ack
);

    if (BURST_LEN < 1 || BURST_LEN > 16) begin : g_bad_burst_len
        $error("rr_mux_scheduler: BURST_LEN must be in 1..16");
    end

    state_t           r_state, w_nxt_state;
    logic [SEL_W-1:0] r_ptr,   w_nxt_ptr;
    logic [SEL_W-1:0] r_sel,   w_nxt_sel;
    logic [N_REQ-1:0] r_gnt,   w_nxt_gnt;
    logic [W-1:0]     r_data,  w_nxt_data;
    logic             r_valid, w_nxt_valid;
    logic [N_REQ-1:0] r_ack,   w_nxt_ack;

`ifdef RR_MUX_SCHEDULER_BURST_EN
    logic [4:0]       r_beats, w_nxt_beats;
`endif

    logic             w_any;
    logic [SEL_W-1:0] w_winner;
    logic [SEL_W-1:0] w_mux_sel;
    logic [W-1:0]     w_mux_out;

    rr_pick u_pick (
        .req    (req),
        .ptr    (r_ptr),
        .any    (w_any),
        .winner (w_winner)
    );

    // Arbitration result steers the mux in IDLE; burst re-capture reuses sel.
    assign w_mux_sel = (r_state == IDLE) ? w_winner : r_sel;

    for (genvar b = 0; b < W; b++) begin : g_lane
        logic [N_REQ-1:0] w_lane;
        for (genvar i = 0; i < N_REQ; i++) begin : g_slot
            assign w_lane[i] = in_data[i*W + b];
        end
        mux16to1 u_mux (
            .d (w_lane),
            .s (w_mux_sel),
            .y (w_mux_out[b])
        );
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_ptr   = r_ptr;
        w_nxt_sel   = r_sel;
        w_nxt_gnt   = r_gnt;
        w_nxt_data  = r_data;
        w_nxt_valid = r_valid;
        w_nxt_ack   = '0;
`ifdef RR_MUX_SCHEDULER_BURST_EN
        w_nxt_beats = r_beats;
`endif
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_nxt_sel   = w_winner;
                    w_nxt_gnt   = onehot4to16(w_winner);
                    w_nxt_data  = w_mux_out;
                    w_nxt_valid = 1'b1;
                    w_nxt_state = GRANT;
`ifdef RR_MUX_SCHEDULER_BURST_EN
                    w_nxt_beats = '0;
`endif
                end
            end
            GRANT: begin
                if (out_ready) begin
                    w_nxt_ack = onehot4to16(r_sel);
`ifdef RR_MUX_SCHEDULER_BURST_EN
                    // r_beats counts beats already accepted before this one.
                    if (req[r_sel] && ({27'd0, r_beats} + 32'd1 < 32'(BURST_LEN))) begin
                        w_nxt_data  = w_mux_out;
                        w_nxt_beats = r_beats + 5'd1;
                    end else begin
                        w_nxt_ptr   = r_sel + 4'd1;
                        w_nxt_valid = 1'b0;
                        w_nxt_gnt   = '0;
                        w_nxt_state = IDLE;
                    end
`else
                    w_nxt_ptr   = r_sel + 4'd1;
                    w_nxt_valid = 1'b0;
                    w_nxt_gnt   = '0;
                    w_nxt_state = IDLE;
`endif
                end
            end
            default: begin
                w_nxt_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_sel   <= '0;
            r_gnt   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ack   <= '0;
`ifdef RR_MUX_SCHEDULER_BURST_EN
            r_beats <= '0;
`endif
        end else begin
            r_state <= w_nxt_state;
            r_ptr   <= w_nxt_ptr;
            r_sel   <= w_nxt_sel;
            r_gnt   <= w_nxt_gnt;
            r_data  <= w_nxt_data;
            r_valid <= w_nxt_valid;
            r_ack   <= w_nxt_ack;
`ifdef RR_MUX_SCHEDULER_BURST_EN
            r_beats <= w_nxt_beats;
`endif
        end
    end

    assign sel       = r_sel;
    assign gnt       = r_gnt;
    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign ack       = r_ack;

endmodule

`default_nettype wire

// File: tb/tb_rr_mux_scheduler.sv
// ============================================================================
// Module : tb_rr_mux_scheduler
// Brief  : Directed self-checking bench for rr_mux_scheduler (W=1).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_mux_scheduler;

    localparam int W = 1;

    logic          clk;
    logic          rst;
    logic [15:0]   req;
    logic [16*W-1:0] in_data;
    logic [3:0]    sel;
    logic [15:0]   gnt;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   ack;

    int n_checks = 0;
    int n_errors = 0;

    rr_mux_scheduler #(
        .W         (W),
        .BURST_LEN (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .in_data   (in_data),
        .sel       (sel),
        .gnt       (gnt),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ack       (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the edge before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " sel"},       32'(sel),       32'd0);
        check({tag, " gnt"},       32'(gnt),       32'd0);
        check({tag, " out_data"},  32'(out_data),  32'd0);
        check({tag, " out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " ack"},       32'(ack),       32'd0);
    endtask

    logic [15:0] pat;
    logic [15:0] oh;

    initial begin
        rst       = 1'b1;
        req       = '0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check_idle_outputs("reset");
        rst = 1'b0;

        // Single request from 0
        req       = 16'h0001;
        in_data   = 16'h0001;
        out_ready = 1'b1;
        tick();
        check("t1 valid", 32'(out_valid), 32'd1);
        check("t1 sel",   32'(sel),       32'd0);
        check("t1 data",  32'(out_data),  32'd1);
        check("t1 gnt",   32'(gnt),       32'h0001);
        check("t1 ack0",  32'(ack),       32'h0000);
        req = '0;
        tick();
        check("t1 ack",    32'(ack),       32'h0001);
        check("t1 valid0", 32'(out_valid), 32'd0);
        check("t1 gnt0",   32'(gnt),       32'h0000);
        // ptr should be 1 now: requester 1 beats requester 0
        req = 16'h0003;
        tick();
        check("t1 ptr1 sel", 32'(sel), 32'd1);
        req = '0;
        tick();
        check("t1 ptr1 ack", 32'(ack), 32'h0002);

        // Full rotation with all 16 requesting
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        req     = 16'hFFFF;
        pat     = 16'hA5C3;
        in_data = pat;
        for (int k = 0; k <= 16; k++) begin
            tick();
            check("rot valid", 32'(out_valid), 32'd1);
            check("rot sel",   32'(sel),       32'(k % 16));
            check("rot data",  32'(out_data),  32'(pat[k % 16]));
            tick();
            oh = 16'h0001 << (k % 16);
            check("rot ack",    32'(ack),       32'(oh));
            check("rot valid0", 32'(out_valid), 32'd0);
        end
        req     = '0;
        in_data = '0;
        tick();

        // Move ptr to 15, then wrap 15 -> 0
        req = 16'h4000;
        tick();
        check("wrap pre sel", 32'(sel), 32'd14);
        req = '0;
        tick();
        check("wrap pre ack", 32'(ack), 32'h4000);
        req = 16'h8001;
        tick();
        check("wrap sel15", 32'(sel), 32'd15);
        tick();
        check("wrap ack15", 32'(ack), 32'h8000);
        tick();
        check("wrap sel0", 32'(sel), 32'd0);
        tick();
        check("wrap ack0", 32'(ack), 32'h0001);
        req = '0;

        // Backpressure on requester 3 with req/data changing underneath
        req       = 16'h0008;
        in_data   = 16'h0008;
        out_ready = 1'b0;
        tick();
        check("bp sel",  32'(sel),      32'd3);
        check("bp data", 32'(out_data), 32'd1);
        req     = '0;
        in_data = '0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp hold valid", 32'(out_valid), 32'd1);
            check("bp hold data",  32'(out_data),  32'd1);
            check("bp hold sel",   32'(sel),       32'd3);
            check("bp hold gnt",   32'(gnt),       32'h0008);
            check("bp hold ack",   32'(ack),       32'h0000);
        end
        out_ready = 1'b1;
        tick();
        check("bp ack",    32'(ack),       32'h0008);
        check("bp valid0", 32'(out_valid), 32'd0);
        tick();
        check("bp ack once", 32'(ack), 32'h0000);

        // Scan order from ptr=4: 6 is reached before 0
        req = 16'h0041;
        tick();
        check("scan sel", 32'(sel), 32'd6);
        req = '0;
        tick();
        check("scan ack", 32'(ack), 32'h0040);

        // Reset while a beat is in flight
        req       = 16'h0010;
        in_data   = 16'h0010;
        out_ready = 1'b0;
        tick();
        check("rstf valid", 32'(out_valid), 32'd1);
        check("rstf sel",   32'(sel),       32'd4);
        rst = 1'b1;
        tick();
        check_idle_outputs("rstf");
        rst     = 1'b0;
        req     = '0;
        in_data = '0;
        tick();
        check("rstf no ack", 32'(ack), 32'h0000);
        req = 16'h8001;
        tick();
        check("rstf ptr0 sel", 32'(sel), 32'd0);
        req       = '0;
        out_ready = 1'b1;
        tick();
        check("rstf ptr0 ack", 32'(ack), 32'h0001);

`ifdef RR_MUX_SCHEDULER_BURST_EN
        // Four-beat burst on requester 5, then rearbitration from ptr=6
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        req     = 16'h0020;
        in_data = 16'h0020;
        tick();
        check("burst b1 valid", 32'(out_valid), 32'd1);
        check("burst b1 sel",   32'(sel),       32'd5);
        check("burst b1 data",  32'(out_data),  32'd1);
        in_data = 16'h0000;
        tick();
        check("burst b2 valid", 32'(out_valid), 32'd1);
        check("burst b2 data",  32'(out_data),  32'd0);
        check("burst b2 ack",   32'(ack),       32'h0020);
        in_data = 16'h0020;
        tick();
        check("burst b3 valid", 32'(out_valid), 32'd1);
        check("burst b3 data",  32'(out_data),  32'd1);
        check("burst b3 ack",   32'(ack),       32'h0020);
        in_data = 16'h0000;
        tick();
        check("burst b4 valid", 32'(out_valid), 32'd1);
        check("burst b4 data",  32'(out_data),  32'd0);
        check("burst b4 ack",   32'(ack),       32'h0020);
        tick();
        check("burst end valid", 32'(out_valid), 32'd0);
        check("burst end ack",   32'(ack),       32'h0020);
        req = 16'h0021;
        tick();
        check("burst rearb sel", 32'(sel), 32'd0);
        req = '0;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
